jtag_debug_ocimem_sequencer: RTL and testbench

Sequences on-chip debug-memory (OCI RAM) accesses requested over JTAG and shares that RAM with the CPU's debug-slave port. Sits on the system-clock side of the CPU JTAG debug module. Consumes the jdo shift data and the ocimem take_action strobes, drives a single-port synchronous RAM, and returns read data and status through MonDReg, monitor_ready and monitor_error to the JTAG scan chain.

---
 rtl/jtag_debug_ocimem_sequencer_pkg.sv | 10 +
 rtl/jtag_debug_ocimem_sequencer_if.sv | 35 +++
 rtl/jtag_debug_ocimem_sequencer_arbiter.sv | 23 ++
 rtl/jtag_debug_ocimem_sequencer.sv | 135 +++++++++++++
 tb/tb_jtag_debug_ocimem_sequencer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtag_debug_ocimem_sequencer_pkg.sv
// jtag_debug_ocimem_sequencer_pkg: shared FSM/pend/grant types and jdo field positions.
package jtag_debug_ocimem_sequencer_pkg;
    typedef enum logic [2:0] {IDLE, J_ACC, J_RD, C_ACC, C_RD} state_e;
    typedef enum logic [1:0] {P_NONE, P_READ, P_WRITE} pend_e;
    typedef enum logic {GR_CPU, GR_JTAG} grant_e;
    localparam int JDO_WDATA_LSB = 3;
    localparam int JDO_WDATA_MSB = 34;
    localparam int JDO_ADDR_LSB  = 2;
    localparam int JDO_RDREQ_BIT = 36;
endpackage

// File: rtl/jtag_debug_ocimem_sequencer_if.sv
// jtag_debug_ocimem_sequencer_if: JTAG strobes, CPU debug-slave bus, RAM port and monitor status.
interface jtag_debug_ocimem_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic              take_no_action_ocimem_a;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_waitrequest;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [31:0]       MonDReg;
    logic              monitor_ready;
    logic              monitor_error;
    modport slave (
        input  jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        output cpu_rdata, cpu_waitrequest, ram_addr, ram_we, ram_wdata,
        output MonDReg, monitor_ready, monitor_error
    );
    modport master (
        output jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        input  cpu_rdata, cpu_waitrequest, ram_addr, ram_we, ram_wdata,
        input  MonDReg, monitor_ready, monitor_error
    );
endinterface

// File: rtl/jtag_debug_ocimem_sequencer_arbiter.sv
// ocimem_rr_arbiter: two-requester arbiter that alternates on ties using the last grant.
module ocimem_rr_arbiter
    import jtag_debug_ocimem_sequencer_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic en_i,
    input  logic req_jtag_i,
    input  logic req_cpu_i,
    output logic gnt_jtag_o,
    output logic gnt_cpu_o
);
    grant_e last_q, last_d;
    always_comb begin
        gnt_jtag_o = en_i && req_jtag_i && (!req_cpu_i || last_q == GR_CPU);
        gnt_cpu_o  = en_i && req_cpu_i && !gnt_jtag_o;
        last_d     = gnt_jtag_o ? GR_JTAG : gnt_cpu_o ? GR_CPU : last_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) last_q <= GR_CPU;
        else          last_q <= last_d;
    end
endmodule

// File: rtl/jtag_debug_ocimem_sequencer.sv
// jtag_debug_ocimem_sequencer: sequences JTAG OCI RAM accesses and shares the RAM with the CPU debug slave.
module jtag_debug_ocimem_sequencer
    import jtag_debug_ocimem_sequencer_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input logic clk,
    input logic reset_n,
    jtag_debug_ocimem_sequencer_if.slave bus
);
    state_e            state_q, state_d;
    pend_e             pend_q, pend_d;
    logic [ADDR_W-1:0] jaddr_q, jaddr_d;
    logic [31:0]       wdata_q, wdata_d, mon_q, mon_d;
    logic              ready_q, ready_d, err_q, err_d;
    logic [DATA_W-1:0] crd_q, crd_d;
    logic              gnt_j, gnt_c, strobe, done;
    logic              unused_jdo_bits;

    assign unused_jdo_bits = ^{bus.jdo[37], bus.jdo[35], bus.jdo[1:0]};

    ocimem_rr_arbiter u_arb (
        .clk        (clk),
        .reset_n    (reset_n),
        .en_i       (state_q == IDLE),
        .req_jtag_i (pend_q != P_NONE),
        .req_cpu_i  (bus.cpu_req),
        .gnt_jtag_o (gnt_j),
        .gnt_cpu_o  (gnt_c)
    );

    always_comb begin
        state_d             = state_q;
        pend_d              = pend_q;
        jaddr_d             = jaddr_q;
        wdata_d             = wdata_q;
        mon_d               = mon_q;
        ready_d             = ready_q;
        err_d               = err_q;
        crd_d               = crd_q;
        done                = 1'b0;
        bus.ram_addr        = '0;
        bus.ram_we          = 1'b0;
        bus.ram_wdata       = '0;
        bus.cpu_waitrequest = 1'b1;
        strobe = bus.take_action_ocimem_a | bus.take_action_ocimem_b | bus.take_no_action_ocimem_a;
        case (state_q)
            IDLE: state_d = gnt_j ? J_ACC : gnt_c ? C_ACC : IDLE;
            J_ACC: begin
                bus.ram_addr = jaddr_q;
                if (pend_q == P_WRITE) begin
                    bus.ram_we    = 1'b1;
                    bus.ram_wdata = wdata_q;
                    done          = 1'b1;
                    state_d       = IDLE;
                end else begin
                    state_d = J_RD;
                end
            end
            J_RD: begin
                mon_d   = bus.ram_rdata;
                done    = 1'b1;
                state_d = IDLE;
            end
            C_ACC: begin
                bus.ram_addr = bus.cpu_addr;
                if (bus.cpu_we) begin
                    bus.ram_we          = 1'b1;
                    bus.ram_wdata       = bus.cpu_wdata;
                    bus.cpu_waitrequest = 1'b0;
                    state_d             = IDLE;
                end else begin
                    state_d = C_RD;
                end
            end
            C_RD: begin
                crd_d               = bus.ram_rdata;
                bus.cpu_waitrequest = 1'b0;
                state_d             = IDLE;
            end
            default: state_d = IDLE;
        endcase
        bus.cpu_rdata = (state_q == C_RD) ? bus.ram_rdata : crd_q;
        if (done) begin
            pend_d  = P_NONE;
            ready_d = 1'b1;
            jaddr_d = jaddr_q + 1'b1;
        end
        // completion and acceptance are exclusive: a strobe only lands while nothing is pending
        if (strobe && pend_q != P_NONE) begin
            err_d = 1'b1;
        end else if (bus.take_action_ocimem_a) begin
            jaddr_d = bus.jdo[JDO_ADDR_LSB+ADDR_W-1:JDO_ADDR_LSB];
            err_d   = 1'b0;
            if (bus.jdo[JDO_RDREQ_BIT]) begin
                pend_d  = P_READ;
                ready_d = 1'b0;
            end
        end else if (bus.take_action_ocimem_b) begin
            pend_d  = P_WRITE;
            wdata_d = bus.jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
            ready_d = 1'b0;
        end else if (bus.take_no_action_ocimem_a) begin
            pend_d  = P_READ;
            ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pend_q  <= P_NONE;
            jaddr_q <= '0;
            wdata_q <= '0;
            mon_q   <= '0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
            crd_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            jaddr_q <= jaddr_d;
            wdata_q <= wdata_d;
            mon_q   <= mon_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            crd_q   <= crd_d;
        end
    end

    assign bus.MonDReg       = mon_q;
    assign bus.monitor_ready = ready_q;
    assign bus.monitor_error = err_q;
endmodule

// File: tb/tb_jtag_debug_ocimem_sequencer.sv
// tb_jtag_debug_ocimem_sequencer: directed scenarios against a synchronous RAM model.
module tb_jtag_debug_ocimem_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] mem [256];
    int          compared = 0;
    int          mismatched = 0;

    jtag_debug_ocimem_sequencer_if bus ();

    jtag_debug_ocimem_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] jdo_addr(input logic [7:0] a, input logic rd);
        logic [37:0] j;
        j = '0;
        j[9:2] = a;
        j[36] = rd;
        return j;
    endfunction

    function automatic logic [37:0] jdo_data(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic strobe_a(input logic [7:0] a, input logic rd);
        bus.jdo = jdo_addr(a, rd);
        bus.take_action_ocimem_a = 1'b1;
        tick();
        bus.take_action_ocimem_a = 1'b0;
    endtask

    task automatic strobe_b(input logic [31:0] d);
        bus.jdo = jdo_data(d);
        bus.take_action_ocimem_b = 1'b1;
        tick();
        bus.take_action_ocimem_b = 1'b0;
    endtask

    task automatic strobe_n();
        bus.take_no_action_ocimem_a = 1'b1;
        tick();
        bus.take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, output int cyc);
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b1;
        bus.cpu_addr = a;
        bus.cpu_wdata = d;
        cyc = 0;
        while (bus.cpu_waitrequest && cyc < 10) begin
            tick();
            cyc++;
        end
        tick();
        bus.cpu_req = 1'b0;
        bus.cpu_we = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] a, output logic [31:0] d, output int cyc);
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = a;
        cyc = 0;
        while (bus.cpu_waitrequest && cyc < 10) begin
            tick();
            cyc++;
        end
        d = bus.cpu_rdata;
        tick();
        bus.cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        bus.jdo = '0;
        bus.take_action_ocimem_a = 1'b0;
        bus.take_action_ocimem_b = 1'b0;
        bus.take_no_action_ocimem_a = 1'b0;
        bus.cpu_req = 1'b0;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_wdata = '0;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        compared++; if (bus.MonDReg !== 32'h0) begin mismatched++; $display("FAIL reset_mondreg: got %h want %h", bus.MonDReg, 32'h0); end
        compared++; if (bus.monitor_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b want 1", bus.monitor_ready); end
        compared++; if (bus.monitor_error !== 1'b0) begin mismatched++; $display("FAIL reset_error: got %b want 0", bus.monitor_error); end
        compared++; if (bus.cpu_waitrequest !== 1'b1) begin mismatched++; $display("FAIL reset_waitreq: got %b want 1", bus.cpu_waitrequest); end
        compared++; if (bus.ram_we !== 1'b0) begin mismatched++; $display("FAIL reset_ram_we: got %b want 0", bus.ram_we); end
        compared++; if (bus.ram_addr !== 8'h0) begin mismatched++; $display("FAIL reset_ram_addr: got %h want 00", bus.ram_addr); end
        compared++; if (bus.cpu_rdata !== 32'h0) begin mismatched++; $display("FAIL reset_cpu_rdata: got %h want 0", bus.cpu_rdata); end
    endtask

    task automatic test_jtag_write();
        strobe_a(8'h10, 1'b0);
        compared++; if (bus.monitor_ready !== 1'b1) begin mismatched++; $display("FAIL jw_addr_ready: got %b want 1", bus.monitor_ready); end
        strobe_b(32'hDEADBEEF);
        compared++; if (bus.monitor_ready !== 1'b0) begin mismatched++; $display("FAIL jw_busy: got %b want 0", bus.monitor_ready); end
        tick();
        compared++; if (bus.ram_we !== 1'b1) begin mismatched++; $display("FAIL jw_ram_we: got %b want 1", bus.ram_we); end
        compared++; if (bus.ram_addr !== 8'h10) begin mismatched++; $display("FAIL jw_ram_addr: got %h want 10", bus.ram_addr); end
        compared++; if (bus.ram_wdata !== 32'hDEADBEEF) begin mismatched++; $display("FAIL jw_ram_wdata: got %h want deadbeef", bus.ram_wdata); end
        tick();
        compared++; if (mem[8'h10] !== 32'hDEADBEEF) begin mismatched++; $display("FAIL jw_mem: got %h want deadbeef", mem[8'h10]); end
        compared++; if (bus.monitor_ready !== 1'b1) begin mismatched++; $display("FAIL jw_done_ready: got %b want 1", bus.monitor_ready); end
        compared++; if (bus.ram_we !== 1'b0) begin mismatched++; $display("FAIL jw_we_low: got %b want 0", bus.ram_we); end
    endtask

    task automatic test_cpu_access();
        int cyc;
        logic [31:0] d;
        cpu_write(8'h20, 32'h12345678, cyc);
        compared++; if (cyc !== 1) begin mismatched++; $display("FAIL cw_latency: got %0d want 1", cyc); end
        cpu_write(8'h21, 32'hCAFEF00D, cyc);
        compared++; if (mem[8'h21] !== 32'hCAFEF00D) begin mismatched++; $display("FAIL cw_mem: got %h want cafef00d", mem[8'h21]); end
        cpu_read(8'h10, d, cyc);
        compared++; if (cyc !== 2) begin mismatched++; $display("FAIL cr_latency: got %0d want 2", cyc); end
        compared++; if (d !== 32'hDEADBEEF) begin mismatched++; $display("FAIL cr_data: got %h want deadbeef", d); end
        compared++; if (bus.cpu_waitrequest !== 1'b1) begin mismatched++; $display("FAIL cr_idle_wait: got %b want 1", bus.cpu_waitrequest); end
    endtask

    task automatic test_jtag_read();
        strobe_a(8'h20, 1'b1);
        compared++; if (bus.monitor_ready !== 1'b0) begin mismatched++; $display("FAIL jr_busy: got %b want 0", bus.monitor_ready); end
        tick();
        compared++; if (bus.ram_addr !== 8'h20) begin mismatched++; $display("FAIL jr_ram_addr: got %h want 20", bus.ram_addr); end
        tick();
        compared++; if (bus.MonDReg !== 32'h0) begin mismatched++; $display("FAIL jr_early: got %h want 0", bus.MonDReg); end
        tick();
        compared++; if (bus.MonDReg !== 32'h12345678) begin mismatched++; $display("FAIL jr_data: got %h want 12345678", bus.MonDReg); end
        compared++; if (bus.monitor_ready !== 1'b1) begin mismatched++; $display("FAIL jr_ready: got %b want 1", bus.monitor_ready); end
        strobe_n();
        tick();
        tick();
        tick();
        compared++; if (bus.MonDReg !== 32'hCAFEF00D) begin mismatched++; $display("FAIL jr_next_data: got %h want cafef00d", bus.MonDReg); end
    endtask

    task automatic test_wrap();
        strobe_a(8'hFF, 1'b0);
        strobe_b(32'hA);
        tick();
        tick();
        strobe_b(32'hB);
        tick();
        tick();
        compared++; if (mem[8'hFF] !== 32'hA) begin mismatched++; $display("FAIL wrap_ff: got %h want 0000000a", mem[8'hFF]); end
        compared++; if (mem[8'h00] !== 32'hB) begin mismatched++; $display("FAIL wrap_00: got %h want 0000000b", mem[8'h00]); end
    endtask

    task automatic test_contention();
        int cyc;
        cpu_write(8'h05, 32'h55AA55AA, cyc);
        strobe_b(32'h77);
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = 8'h05;
        tick();
        compared++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== 8'h01) begin mismatched++; $display("FAIL tie1_jtag_first: got we=%b addr=%h want we=1 addr=01", bus.ram_we, bus.ram_addr); end
        compared++; if (bus.cpu_waitrequest !== 1'b1) begin mismatched++; $display("FAIL tie1_cpu_wait: got %b want 1", bus.cpu_waitrequest); end
        tick();
        tick();
        compared++; if (bus.ram_addr !== 8'h05 || bus.cpu_waitrequest !== 1'b1) begin mismatched++; $display("FAIL tie1_cpu_acc: got addr=%h wait=%b want addr=05 wait=1", bus.ram_addr, bus.cpu_waitrequest); end
        tick();
        compared++; if (bus.cpu_waitrequest !== 1'b0 || bus.cpu_rdata !== 32'h55AA55AA) begin mismatched++; $display("FAIL tie1_cpu_rd: got wait=%b data=%h want wait=0 data=55aa55aa", bus.cpu_waitrequest, bus.cpu_rdata); end
        tick();
        bus.cpu_req = 1'b0;
        compared++; if (mem[8'h01] !== 32'h77) begin mismatched++; $display("FAIL tie1_mem: got %h want 00000077", mem[8'h01]); end
        strobe_b(32'h88);
        tick();
        tick();
        strobe_b(32'h99);
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = 8'h05;
        tick();
        compared++; if (bus.ram_we !== 1'b0 || bus.ram_addr !== 8'h05) begin mismatched++; $display("FAIL tie2_cpu_first: got we=%b addr=%h want we=0 addr=05", bus.ram_we, bus.ram_addr); end
        tick();
        compared++; if (bus.cpu_waitrequest !== 1'b0 || bus.cpu_rdata !== 32'h55AA55AA) begin mismatched++; $display("FAIL tie2_cpu_rd: got wait=%b data=%h want wait=0 data=55aa55aa", bus.cpu_waitrequest, bus.cpu_rdata); end
        tick();
        bus.cpu_req = 1'b0;
        tick();
        compared++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== 8'h03) begin mismatched++; $display("FAIL tie2_jtag_after: got we=%b addr=%h want we=1 addr=03", bus.ram_we, bus.ram_addr); end
        tick();
        compared++; if (mem[8'h03] !== 32'h99 || mem[8'h02] !== 32'h88) begin mismatched++; $display("FAIL tie2_mem: got %h/%h want 00000088/00000099", mem[8'h02], mem[8'h03]); end
    endtask

    task automatic test_overrun();
        strobe_b(32'h11111111);
        strobe_b(32'h22222222);
        compared++; if (bus.monitor_error !== 1'b1) begin mismatched++; $display("FAIL ovr_error: got %b want 1", bus.monitor_error); end
        tick();
        compared++; if (mem[8'h04] !== 32'h11111111 || bus.monitor_ready !== 1'b1) begin mismatched++; $display("FAIL ovr_first: got mem=%h ready=%b want mem=11111111 ready=1", mem[8'h04], bus.monitor_ready); end
        tick();
        tick();
        compared++; if (mem[8'h05] !== 32'h55AA55AA) begin mismatched++; $display("FAIL ovr_ignored: got %h want 55aa55aa", mem[8'h05]); end
        compared++; if (bus.monitor_error !== 1'b1) begin mismatched++; $display("FAIL ovr_sticky: got %b want 1", bus.monitor_error); end
        strobe_a(8'h30, 1'b0);
        compared++; if (bus.monitor_error !== 1'b0) begin mismatched++; $display("FAIL ovr_clear: got %b want 0", bus.monitor_error); end
    endtask

    task automatic test_async_reset();
        strobe_a(8'h20, 1'b1);
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        compared++; if (bus.monitor_ready !== 1'b1) begin mismatched++; $display("FAIL arst_ready: got %b want 1", bus.monitor_ready); end
        compared++; if (bus.MonDReg !== 32'h0) begin mismatched++; $display("FAIL arst_mondreg: got %h want 0", bus.MonDReg); end
        reset_n = 1'b1;
        tick();
        tick();
        tick();
        tick();
        compared++; if (bus.MonDReg !== 32'h0 || bus.monitor_ready !== 1'b1) begin mismatched++; $display("FAIL arst_lost: got mon=%h ready=%b want mon=0 ready=1", bus.MonDReg, bus.monitor_ready); end
        strobe_b(32'h5A5A5A5A);
        tick();
        compared++; if (bus.ram_we !== 1'b1) begin mismatched++; $display("FAIL arst_we_pre: got %b want 1", bus.ram_we); end
        #2 reset_n = 1'b0;
        #1;
        compared++; if (bus.ram_we !== 1'b0) begin mismatched++; $display("FAIL arst_we_drop: got %b want 0", bus.ram_we); end
        reset_n = 1'b1;
        tick();
        tick();
        compared++; if (mem[8'h00] !== 32'hB) begin mismatched++; $display("FAIL arst_no_write: got %h want 0000000b", mem[8'h00]); end
    endtask

    initial begin
        test_reset();
        test_jtag_write();
        test_cpu_access();
        test_jtag_read();
        test_wrap();
        test_contention();
        test_overrun();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
